// File: rtl/mdu_iter.sv
// Iterative RV32 M-extension unit: shift-add multiplier and restoring divider,
// one bit per cycle, with valid/ready handshakes on request and result sides.
module mdu_iter #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   src1,
    input  logic [XLEN-1:0]   src2,
    input  logic [REG_AW-1:0] rd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic [REG_AW-1:0] rd_out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic                neg_q, neg_d;
    logic                rem_neg_q, rem_neg_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                sgn1, sgn2;
    logic [XLEN-1:0]     mag1, mag2;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_trial;
    logic                div_ge;
    logic [XLEN-1:0]     div_diff;
    logic [2*XLEN-1:0]   div_next;
    logic [2*XLEN-1:0]   iter_next;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo, rem;
    logic [XLEN-1:0]     final_res;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign rd_out    = rd_q;

    // Operand sign handling at accept time.
    always_comb begin
        sgn1 = 1'b0;
        sgn2 = 1'b0;
        case (op)
            OP_MULH, OP_DIV, OP_REM: begin
                sgn1 = src1[XLEN-1];
                sgn2 = src2[XLEN-1];
            end
            OP_MULHSU: sgn1 = src1[XLEN-1];
            default: ;
        endcase
        mag1 = sgn1 ? (~src1 + 1'b1) : src1;
        mag2 = sgn2 ? (~src2 + 1'b1) : src2;
    end

    // One iteration step; acc low half holds the multiplier or the dividend/quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
        mul_next  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
        div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge    = (div_trial >= {1'b0, opb_q});
        div_diff  = div_trial[XLEN-1:0] - opb_q;
        div_next  = {(div_ge ? div_diff : div_trial[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
        iter_next = op_q[2] ? div_next : mul_next;
        prod_fix  = neg_q ? (~iter_next + 1'b1) : iter_next;
        quo       = iter_next[XLEN-1:0];
        rem       = iter_next[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       final_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_res = neg_q ? (~quo + 1'b1) : quo;
            default:                      final_res = rem_neg_q ? (~rem + 1'b1) : rem;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_d      = rd_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_d      = op;
                        rd_d      = rd_in;
                        cnt_d     = '0;
                        neg_d     = sgn1 ^ sgn2;
                        rem_neg_d = sgn1;
                        if (op[2] && (src2 == '0)) begin
                            result_d = op[1] ? src1 : '1;
                            state_d  = DONE;
                        end else if (op[2] && !op[0] && (src1 == INT_MIN) && (src2 == '1)) begin
                            result_d = op[1] ? '0 : INT_MIN;
                            state_d  = DONE;
                        end else begin
                            acc_d   = op[2] ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
                            opb_d   = op[2] ? mag2 : mag1;
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    acc_d = iter_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_d = final_res;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter: arithmetic results, latency, backpressure,
// flush and asynchronous reset.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] src1, src2;
    logic [4:0]  rd_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    mdu_iter #(.XLEN(32), .REG_AW(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .rd_in    (rd_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .rd_out   (rd_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one request; returns after out_valid is seen (or timeout), without popping it.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat);
        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1);
        op = f3; src1 = a; src2 = b; rd_in = rd; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src1 = 32'hDEAD_BEEF; src2 = 32'h1234_5678; op = ~f3; rd_in = ~rd;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("in_ready_after_pop", in_ready, 1);
        check("out_valid_after_pop", out_valid, 0);
    endtask

    task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp_res, input int exp_lat);
        int lat;
        issue(f3, a, b, rd, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_rd"}, rd_out, rd);
        pop();
    endtask

    initial begin
        int lat;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; src1 = '0; src2 = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 0);
        check("rst_rd", rd_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;

        run("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
        run("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 33);
        run("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33);
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 33);
        run("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 33);
        run("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 33);
        run("divu",   3'b101, 32'd100,       32'd7,         5'd11, 32'd14,        33);
        run("remu",   3'b111, 32'd100,       32'd7,         5'd0,  32'd2,         33);
        run("divu0",  3'b101, 32'd5,         32'd0,         5'd12, 32'hFFFF_FFFF, 1);
        run("remu0",  3'b111, 32'd5,         32'd0,         5'd13, 32'd5,         1);
        run("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
        run("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000, 1);

        // Backpressure: result held for 10 cycles with out_ready low.
        issue(3'b000, 32'd6, 32'd9, 5'd21, lat);
        check("bp_lat", lat, 33);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", out_valid, 1);
            check("bp_res", result, 32'd54);
            check("bp_rd", rd_out, 21);
            check("bp_in_ready", in_ready, 0);
        end
        pop();

        // Flush after 10 CALC cycles, with a competing request that must be ignored.
        @(negedge clk);
        op = 3'b000; src1 = 32'd2; src2 = 32'd3; rd_in = 5'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("flush_pre_busy", busy, 1);
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_busy", busy, 0);
        check("flush_in_ready", in_ready, 1);
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) check("flush_no_result", out_valid, 0);
        end
        check("flush_idle_after", busy, 0);

        // Reset mid-CALC after a prior nonzero result.
        run("prev", 3'b101, 32'd81, 32'd9, 5'd17, 32'd9, 33);
        @(negedge clk);
        op = 3'b000; src1 = 32'd100; src2 = 32'd100; rd_in = 5'd19; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_result", result, 0);
        check("arst_rd", rd_out, 0);
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;

        run("mul3x4", 3'b000, 32'd3, 32'd4, 5'd2, 32'd12, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
